// File: rtl/sd_drive_arbiter_if.sv
// HPS virtual-disk channel bundle between the drive arbiter (master) and the HPS side (slave).
interface sd_drive_arbiter_if #(
    parameter int NDRIVES = 4,
    parameter int LBA_W   = 32
);
    logic [NDRIVES*LBA_W-1:0] sd_lba;
    logic [NDRIVES-1:0]       sd_rd;
    logic [NDRIVES-1:0]       sd_wr;
    logic [NDRIVES-1:0]       sd_ack;
    logic [8:0]               sd_buff_addr;
    logic [7:0]               sd_buff_dout;
    logic                     sd_buff_wr;
    logic [NDRIVES*8-1:0]     sd_buff_din;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/sd_drive_arbiter.sv
// Round-robin arbiter granting one drive controller at a time onto the HPS virtual-disk channel.
//
//   state  | meaning
//   IDLE   | no grant; picks next pending drive starting at rp
//   REQ    | sd_rd/sd_wr held on granted lane, waiting for sd_ack or timeout
//   XFER   | buffer traffic routed to/from granted drive until sd_ack falls
//   FIN    | one-cycle done/err pulse, advance rp, release grant
module sd_drive_arbiter #(
    parameter int NDRIVES = 4,
    parameter int LBA_W   = 32,
    parameter int TIMEOUT = 16777216
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [NDRIVES-1:0]       drv_rd,
    input  logic [NDRIVES-1:0]       drv_wr,
    input  logic [NDRIVES*LBA_W-1:0] drv_lba,
    input  logic [NDRIVES*8-1:0]     drv_buff_din,
    output logic [NDRIVES-1:0]       drv_busy,
    output logic [NDRIVES-1:0]       drv_done,
    output logic [NDRIVES-1:0]       drv_err,
    output logic [NDRIVES-1:0]       drv_buff_wr,
    output logic [8:0]               buff_addr,
    output logic [7:0]               buff_dout,
    input  logic [NDRIVES-1:0]       img_mounted,
    sd_drive_arbiter_if.master       hps
);

    localparam int GW    = (NDRIVES > 1) ? $clog2(NDRIVES) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [NDRIVES-1:0]   pend_q, pend_d;
    logic [NDRIVES-1:0]   op_q, op_d;
    logic [LBA_W-1:0]     lba_q [NDRIVES];
    logic [LBA_W-1:0]     lba_d [NDRIVES];
    logic [GW-1:0]        g_q, g_d;
    logic [GW-1:0]        rp_q, rp_d;
    logic                 act_op_q, act_op_d;
    logic [LBA_W-1:0]     act_lba_q, act_lba_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NDRIVES-1:0]   busy_q, busy_d;
    logic                 req_q, req_d;
    logic [NDRIVES-1:0]   buff_wr_q, buff_wr_d;
    logic [8:0]           buff_addr_q, buff_addr_d;
    logic [7:0]           buff_dout_q, buff_dout_d;

    logic [NDRIVES-1:0]   req_pulse;
    logic [NDRIVES-1:0]   pend_eff;
    logic [GW-1:0]        pick;
    logic                 pick_vld;
    logic                 grant_now;
    logic [7:0]           din_sel;

    assign req_pulse = drv_rd | drv_wr;
    // The granted drive keeps its queued request across a mount pulse.
    assign pend_eff  = req_pulse | (pend_q & ~(img_mounted & ~busy_q));

    always_comb begin
        for (int i = 0; i < NDRIVES; i++) begin
            op_d[i]  = req_pulse[i] ? drv_wr[i] : op_q[i];
            lba_d[i] = req_pulse[i] ? drv_lba[i*LBA_W +: LBA_W] : lba_q[i];
        end
    end

    always_comb begin
        int            j;
        logic [GW-1:0] jj;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NDRIVES; k++) begin
            j = int'(rp_q) + k;
            if (j >= NDRIVES) begin
                j = j - NDRIVES;
            end
            jj = GW'(j);
            if (!pick_vld && pend_eff[jj]) begin
                pick     = jj;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        pend_d = pend_eff;
        if (grant_now) begin
            pend_d[pick] = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rp_d        = rp_q;
        act_op_d    = act_op_q;
        act_lba_d   = act_lba_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        req_d       = req_q;
        buff_wr_d   = '0;
        buff_addr_d = buff_addr_q;
        buff_dout_d = buff_dout_q;
        grant_now   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_now = 1'b1;
                    g_d       = pick;
                    act_op_d  = op_d[pick];
                    act_lba_d = lba_d[pick];
                    busy_d    = NDRIVES'(1) << pick;
                    req_d     = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (hps.sd_ack[g_q]) begin
                    req_d   = 1'b0;
                    state_d = S_XFER;
                end else if (TIMEOUT != 0 && cnt_q == '0) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_XFER: begin
                buff_addr_d = hps.sd_buff_addr;
                buff_dout_d = hps.sd_buff_dout;
                buff_wr_d   = hps.sd_buff_wr ? busy_q : '0;
                if (!hps.sd_ack[g_q]) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                busy_d  = '0;
                err_d   = 1'b0;
                cnt_d   = '0;
                rp_d    = (g_q == GW'(NDRIVES - 1)) ? '0 : g_q + GW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            op_q        <= '0;
            for (int i = 0; i < NDRIVES; i++) begin
                lba_q[i] <= '0;
            end
            g_q         <= '0;
            rp_q        <= '0;
            act_op_q    <= 1'b0;
            act_lba_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= '0;
            req_q       <= 1'b0;
            buff_wr_q   <= '0;
            buff_addr_q <= '0;
            buff_dout_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            op_q        <= op_d;
            lba_q       <= lba_d;
            g_q         <= g_d;
            rp_q        <= rp_d;
            act_op_q    <= act_op_d;
            act_lba_q   <= act_lba_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            req_q       <= req_d;
            buff_wr_q   <= buff_wr_d;
            buff_addr_q <= buff_addr_d;
            buff_dout_q <= buff_dout_d;
        end
    end

    // busy_q is one-hot on the granted lane, so it doubles as the write-data select.
    always_comb begin
        din_sel = '0;
        for (int i = 0; i < NDRIVES; i++) begin
            if (busy_q[i]) begin
                din_sel = drv_buff_din[i*8 +: 8];
            end
        end
    end

    assign drv_busy        = busy_q;
    assign drv_done        = (state_q == S_FIN) ? busy_q : '0;
    assign drv_err         = (state_q == S_FIN && err_q) ? busy_q : '0;
    assign drv_buff_wr     = buff_wr_q;
    assign buff_addr       = buff_addr_q;
    assign buff_dout       = buff_dout_q;
    assign hps.sd_rd       = (req_q && !act_op_q) ? busy_q : '0;
    assign hps.sd_wr       = (req_q && act_op_q) ? busy_q : '0;
    assign hps.sd_lba      = {NDRIVES{act_lba_q}};
    assign hps.sd_buff_din = {NDRIVES{din_sel}};

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Directed bench for sd_drive_arbiter: main instance plus a short-timeout instance.
module tb_sd_drive_arbiter;

    logic         clk_sys = 1'b0;
    logic         reset   = 1'b1;
    logic [3:0]   drv_rd = '0, drv_wr = '0, img_mounted = '0;
    logic [127:0] drv_lba = '0;
    logic [31:0]  drv_buff_din = '0;
    logic [3:0]   drv_busy, drv_done, drv_err, drv_buff_wr;
    logic [8:0]   buff_addr;
    logic [7:0]   buff_dout;

    logic [3:0]   t_rd = '0;
    logic [3:0]   t_busy, t_done, t_err, t_buff_wr;
    logic [8:0]   t_buff_addr;
    logic [7:0]   t_buff_dout;

    int n_assert = 0;
    int n_fail   = 0;

    sd_drive_arbiter_if #(.NDRIVES(4), .LBA_W(32)) hps_if ();
    sd_drive_arbiter_if #(.NDRIVES(4), .LBA_W(32)) to_if ();

    sd_drive_arbiter #(.NDRIVES(4), .LBA_W(32), .TIMEOUT(64)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .drv_rd(drv_rd), .drv_wr(drv_wr), .drv_lba(drv_lba), .drv_buff_din(drv_buff_din),
        .drv_busy(drv_busy), .drv_done(drv_done), .drv_err(drv_err), .drv_buff_wr(drv_buff_wr),
        .buff_addr(buff_addr), .buff_dout(buff_dout), .img_mounted(img_mounted),
        .hps(hps_if)
    );

    sd_drive_arbiter #(.NDRIVES(4), .LBA_W(32), .TIMEOUT(4)) dut_to (
        .clk_sys(clk_sys), .reset(reset),
        .drv_rd(t_rd), .drv_wr(4'b0000), .drv_lba(128'h0), .drv_buff_din(32'h0),
        .drv_busy(t_busy), .drv_done(t_done), .drv_err(t_err), .drv_buff_wr(t_buff_wr),
        .buff_addr(t_buff_addr), .buff_dout(t_buff_dout), .img_mounted(4'b0000),
        .hps(to_if)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered in the REQ cycle; acks instantly, ends in the IDLE cycle after FIN.
    task automatic serve(input string tag, input logic [3:0] exp_rd, input logic [3:0] exp_wr);
        chk({tag, "_rd"}, hps_if.sd_rd, exp_rd);
        chk({tag, "_wr"}, hps_if.sd_wr, exp_wr);
        chk({tag, "_busy"}, drv_busy, exp_rd | exp_wr);
        hps_if.sd_ack = exp_rd | exp_wr;
        step();
        drv_rd = '0;
        drv_wr = '0;
        hps_if.sd_ack = '0;
        step();
        chk({tag, "_done"}, drv_done, exp_rd | exp_wr);
        chk({tag, "_err"}, drv_err, 4'b0000);
        step();
        chk({tag, "_idle"}, drv_busy, 4'b0000);
    endtask

    initial begin
        int bad;
        hps_if.sd_ack = '0; hps_if.sd_buff_addr = '0; hps_if.sd_buff_dout = '0; hps_if.sd_buff_wr = 1'b0;
        to_if.sd_ack  = '0; to_if.sd_buff_addr  = '0; to_if.sd_buff_dout  = '0; to_if.sd_buff_wr  = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_busy", drv_busy, 4'b0000);
        chk("rst_sd_rd", hps_if.sd_rd, 4'b0000);
        chk("rst_sd_wr", hps_if.sd_wr, 4'b0000);
        chk("rst_done", drv_done, 4'b0000);
        chk("rst_sd_lba", hps_if.sd_lba, 128'h0);

        // Round robin: 0, 1, 3 together; 0 again while 1 is active -> 3 before 0.
        drv_lba[0*32 +: 32] = 32'h100;
        drv_lba[1*32 +: 32] = 32'h101;
        drv_lba[3*32 +: 32] = 32'h103;
        drv_rd = 4'b1011;
        step();
        drv_rd = '0;
        chk("rr0_lba", hps_if.sd_lba, {4{32'h100}});
        serve("rr0", 4'b0001, 4'b0000);
        chk("rr_gap", hps_if.sd_rd, 4'b0000);
        step();
        chk("rr1_lba", hps_if.sd_lba, {4{32'h101}});
        drv_lba[0*32 +: 32] = 32'h200;
        drv_rd = 4'b0001;
        serve("rr1", 4'b0010, 4'b0000);
        step();
        chk("rr3_lba", hps_if.sd_lba, {4{32'h103}});
        serve("rr3", 4'b1000, 4'b0000);
        step();
        chk("rr0b_lba", hps_if.sd_lba, {4{32'h200}});
        serve("rr0b", 4'b0001, 4'b0000);

        // Write routing on drive 1.
        drv_buff_din = 32'h0000A500;
        drv_wr = 4'b0010;
        step();
        drv_wr = '0;
        chk("wr_din", hps_if.sd_buff_din, 32'hA5A5A5A5);
        serve("wr1", 4'b0000, 4'b0010);
        chk("wr_din_released", hps_if.sd_buff_din, 32'h0);
        drv_buff_din = '0;

        // Single read on drive 2, ack 3 cycles after sd_rd, 256 interleaved strobes.
        drv_lba[2*32 +: 32] = 32'h00001234;
        drv_rd = 4'b0100;
        step();
        drv_rd = '0;
        chk("rd_sd_rd", hps_if.sd_rd, 4'b0100);
        chk("rd_sd_lba", hps_if.sd_lba, {4{32'h00001234}});
        step(); step(); step();
        hps_if.sd_ack = 4'b0100;
        chk("rd_sd_rd_held", hps_if.sd_rd, 4'b0100);
        step();
        chk("rd_sd_rd_drop", hps_if.sd_rd, 4'b0000);
        chk("rd_bwr_first", drv_buff_wr, 4'b0000);
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            hps_if.sd_buff_wr   = k[0];
            hps_if.sd_buff_addr = 9'(k >> 1);
            hps_if.sd_buff_dout = 8'(k >> 1) ^ 8'h5A;
            if (k == 511) hps_if.sd_ack = 4'b0000;
            step();
            if (drv_buff_wr !== (k[0] ? 4'b0100 : 4'b0000)) bad++;
            if (buff_addr !== 9'(k >> 1) || buff_dout !== (8'(k >> 1) ^ 8'h5A)) bad++;
            if (k < 511 && (drv_done !== 4'b0000 || drv_err !== 4'b0000)) bad++;
        end
        chk("rd_strobes_bad", 128'(bad), 128'd0);
        chk("rd_tail_bwr", drv_buff_wr, 4'b0100);
        chk("rd_done", drv_done, 4'b0100);
        chk("rd_err", drv_err, 4'b0000);
        hps_if.sd_buff_wr = 1'b0;
        step();
        chk("rd_done_once", drv_done, 4'b0000);
        chk("rd_bwr_after", drv_buff_wr, 4'b0000);
        chk("rd_busy_after", drv_busy, 4'b0000);

        // Mount clears pending drive 1; foreign ack on lane 2 is ignored.
        drv_lba[0*32 +: 32] = 32'h300;
        drv_rd = 4'b0001;
        step();
        chk("mnt_rd0", hps_if.sd_rd, 4'b0001);
        drv_rd = 4'b0010;
        hps_if.sd_ack = 4'b0100;
        step();
        chk("mnt_foreign_ack", hps_if.sd_rd, 4'b0001);
        drv_rd = '0;
        img_mounted = 4'b0010;
        hps_if.sd_ack = 4'b0000;
        step();
        img_mounted = '0;
        hps_if.sd_ack = 4'b0100;
        step();
        chk("mnt_still_req", hps_if.sd_rd, 4'b0001);
        chk("mnt_lba", hps_if.sd_lba, {4{32'h300}});
        hps_if.sd_ack = 4'b0101;
        step();
        chk("mnt_xfer", hps_if.sd_rd, 4'b0000);
        hps_if.sd_ack = 4'b0100;
        step();
        chk("mnt_done", drv_done, 4'b0001);
        hps_if.sd_ack = 4'b0000;
        step(); step();
        chk("mnt_no_grant_rd", hps_if.sd_rd, 4'b0000);
        chk("mnt_no_grant_busy", drv_busy, 4'b0000);

        // Reset during XFER.
        drv_lba[2*32 +: 32] = 32'h444;
        drv_rd = 4'b0100;
        step();
        drv_rd = '0;
        hps_if.sd_ack = 4'b0100;
        step();
        hps_if.sd_buff_wr = 1'b1; hps_if.sd_buff_addr = 9'h055; hps_if.sd_buff_dout = 8'h66;
        step();
        chk("rx_pre_bwr", drv_buff_wr, 4'b0100);
        reset = 1'b1;
        step();
        chk("rx_busy", drv_busy, 4'b0000);
        chk("rx_sd_rd", hps_if.sd_rd, 4'b0000);
        chk("rx_done", drv_done, 4'b0000);
        chk("rx_bwr", drv_buff_wr, 4'b0000);
        chk("rx_baddr", buff_addr, 9'h000);
        chk("rx_lba", hps_if.sd_lba, 128'h0);
        reset = 1'b0;
        hps_if.sd_ack = '0; hps_if.sd_buff_wr = 1'b0; hps_if.sd_buff_addr = '0; hps_if.sd_buff_dout = '0;
        step();
        chk("rx_no_done", drv_done, 4'b0000);
        drv_lba[3*32 +: 32] = 32'h999;
        drv_wr = 4'b1000;
        step();
        drv_wr = '0;
        chk("rx_fresh_lba", hps_if.sd_lba, {4{32'h999}});
        serve("rx_fresh", 4'b0000, 4'b1000);

        // Timeout instance: TIMEOUT=4, ack never arrives.
        t_rd = 4'b0001;
        step();
        t_rd = '0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("to_rd_c%0d", c), to_if.sd_rd, 4'b0001);
            chk($sformatf("to_nodone_c%0d", c), t_done, 4'b0000);
            step();
        end
        chk("to_rd_drop", to_if.sd_rd, 4'b0000);
        chk("to_done", t_done, 4'b0001);
        chk("to_err", t_err, 4'b0001);
        step();
        chk("to_done_clr", t_done, 4'b0000);
        chk("to_err_clr", t_err, 4'b0000);
        chk("to_idle_busy", t_busy, 4'b0000);
        t_rd = 4'b0010;
        step();
        t_rd = '0;
        chk("to_regrant", to_if.sd_rd, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
